uart_tx_scheduler: RTL and testbench

Round-robin scheduler that shares one byte-wide UART transmitter among several packet requesters. Each requester offers a packet of up to 8 bytes as a 64-bit buffer plus a byte count. The scheduler grants one requester and latches its packet. It feeds the bytes LSB-first to the downstream byte transmitter using a start/busy handshake, then enforces an idle gap before the next packet. It sits between the application logic and the UART bit-serializer on the 50 MHz domain.

---
 rtl/uart_tx_scheduler_pkg.sv | 38 +++
 rtl/uart_tx_scheduler_rr_arbiter.sv | 50 +++++
 rtl/uart_tx_scheduler.sv | 188 ++++++++++++++++++
 tb/tb_uart_tx_scheduler.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_scheduler_pkg.sv
// Shared types and constants for the UART transmit scheduler.
// Contents:
//   state_t      - controller FSM states
//   COUNT_W      - width of a requester byte count
//   BYTE_W       - width of one transmitted byte
//   PKT_W        - width of one requester packet buffer
//   IDX_W        - width of a requester index (up to 8 requesters)
//   clamp_count  - limits a requested byte count to the packet capacity
package uart_tx_sched_pkg;

    localparam int COUNT_W = 4;
    localparam int BYTE_W  = 8;
    localparam int PKT_W   = 64;
    localparam int IDX_W   = 3;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SEND    = 3'd1,
        WAIT_HI = 3'd2,
        WAIT_LO = 3'd3,
        GAP     = 3'd4
    } state_t;

    // Oversized counts are treated as a full packet rather than rejected.
    function automatic logic [COUNT_W-1:0] clamp_count(
        input logic [COUNT_W-1:0] count,
        input logic [COUNT_W-1:0] max_count
    );
        logic [COUNT_W-1:0] result;
        if (count > max_count) begin
            result = max_count;
        end else begin
            result = count;
        end
        return result;
    endfunction

endpackage

// File: rtl/uart_tx_scheduler_rr_arbiter.sv
// Round-robin arbiter for the UART transmit scheduler.
// Purely combinational: picks the first requester at or after
// (last_grant + 1) with wrap-around. The pointer itself is held by the parent.
// Ports:
//   req        in   NUM_REQ  pending requests
//   last_grant in   IDX_W    index granted most recently
//   grant      out  NUM_REQ  one-hot grant (all zero when nothing pending)
//   grant_idx  out  IDX_W    binary index of the granted requester
//   any_grant  out  1        a requester was selected
module rr_arbiter
    import uart_tx_sched_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last_grant,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               any_grant
);

    logic found_s;

    // Two passes: requesters above the pointer first, then wrap to the ones at or below it.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found_s   = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found_s && req[i] && (i > int'(last_grant))) begin
                grant[i]  = 1'b1;
                grant_idx = IDX_W'(i);
                found_s   = 1'b1;
            end else begin
                found_s   = found_s;
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found_s && req[i] && (i <= int'(last_grant))) begin
                grant[i]  = 1'b1;
                grant_idx = IDX_W'(i);
                found_s   = 1'b1;
            end else begin
                found_s   = found_s;
            end
        end
        any_grant = found_s;
    end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler sharing one byte-wide UART transmitter among
// NUM_REQ packet requesters. A granted packet (up to 8 bytes) is sent
// LSB-first with a start/busy handshake, followed by GAP_CYCLES idle cycles.
// Ports:
//   CLOCK_50M  in   1            system clock
//   RESET_N    in   1            asynchronous active-low reset
//   req_valid  in   NUM_REQ      requester i has a packet pending
//   req_data   in   NUM_REQ*64   packet of requester i, byte 0 in bits [7:0]
//   req_count  in   NUM_REQ*4    byte count of requester i (clamped to MAX_BYTES)
//   req_ready  out  NUM_REQ      one-cycle accept pulse
//   tx_data    out  8            byte for the transmitter
//   tx_start   out  1            one-cycle transmit request
//   tx_busy    in   1            transmitter is shifting a byte
//   grant_id   out  3            current or last granted requester
//   active     out  1            high from grant until the end of the gap
module uart_tx_scheduler
    import uart_tx_sched_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int MAX_BYTES  = 8,
    parameter int GAP_CYCLES = 5208
) (
    input  logic                       CLOCK_50M,
    input  logic                       RESET_N,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*PKT_W-1:0]   req_data,
    input  logic [NUM_REQ*COUNT_W-1:0] req_count,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic [BYTE_W-1:0]          tx_data,
    output logic                       tx_start,
    input  logic                       tx_busy,
    output logic [IDX_W-1:0]           grant_id,
    output logic                       active
);

    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES + 1) : 1;
    localparam logic [GAP_W-1:0]   GAP_LOAD = GAP_W'((GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0);
    localparam logic [COUNT_W-1:0] MAX_CNT  = COUNT_W'(MAX_BYTES);

    state_t               state_r;
    logic [IDX_W-1:0]     last_grant_r;
    logic [PKT_W-1:0]     shift_r;
    logic [COUNT_W-1:0]   remain_r;
    logic [GAP_W-1:0]     gap_cnt_r;
    logic [NUM_REQ-1:0]   req_ready_r;
    logic [BYTE_W-1:0]    tx_data_r;
    logic                 tx_start_r;
    logic [IDX_W-1:0]     grant_id_r;
    logic                 active_r;

    logic [NUM_REQ-1:0]   avail_s;
    logic [NUM_REQ-1:0]   grant_s;
    logic [IDX_W-1:0]     grant_idx_s;
    logic                 any_s;
    logic [PKT_W-1:0]     sel_data_s;
    logic [COUNT_W-1:0]   sel_count_s;
    logic [COUNT_W-1:0]   clamped_s;

    // A requester still sees its accept pulse for one cycle; masking it stops
    // a zero-length packet from being granted twice back to back.
    always_comb begin
        avail_s = req_valid & ~req_ready_r;
    end

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .req        (avail_s),
        .last_grant (last_grant_r),
        .grant      (grant_s),
        .grant_idx  (grant_idx_s),
        .any_grant  (any_s)
    );

    // AND-OR select of the granted requester's packet and count.
    always_comb begin
        sel_data_s  = '0;
        sel_count_s = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_s[i]) begin
                sel_data_s  = sel_data_s  | req_data[i*PKT_W +: PKT_W];
                sel_count_s = sel_count_s | req_count[i*COUNT_W +: COUNT_W];
            end else begin
                sel_data_s  = sel_data_s;
                sel_count_s = sel_count_s;
            end
        end
        clamped_s = clamp_count(sel_count_s, MAX_CNT);
    end

    // Controller FSM with all outputs registered.
    always_ff @(posedge CLOCK_50M or negedge RESET_N) begin
        if (!RESET_N) begin
            state_r      <= IDLE;
            last_grant_r <= IDX_W'(NUM_REQ - 1);
            shift_r      <= '0;
            remain_r     <= '0;
            gap_cnt_r    <= '0;
            req_ready_r  <= '0;
            tx_data_r    <= '0;
            tx_start_r   <= 1'b0;
            grant_id_r   <= '0;
            active_r     <= 1'b0;
        end else begin
            req_ready_r <= '0;
            tx_start_r  <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (any_s) begin
                        req_ready_r  <= grant_s;
                        grant_id_r   <= grant_idx_s;
                        last_grant_r <= grant_idx_s;
                        shift_r      <= sel_data_s;
                        remain_r     <= clamped_s;
                        // An empty packet is accepted and dropped: nothing is
                        // sent, so the line never becomes active and no gap follows.
                        if (clamped_s == '0) begin
                            active_r <= 1'b0;
                            state_r  <= IDLE;
                        end else begin
                            active_r <= 1'b1;
                            state_r  <= SEND;
                        end
                    end else begin
                        state_r <= IDLE;
                    end
                end
                SEND: begin
                    if (!tx_busy) begin
                        tx_start_r <= 1'b1;
                        tx_data_r  <= shift_r[BYTE_W-1:0];
                        shift_r    <= {8'h00, shift_r[PKT_W-1:BYTE_W]};
                        if (remain_r != '0) begin
                            remain_r <= remain_r - 4'd1;
                        end else begin
                            remain_r <= remain_r;
                        end
                        state_r <= WAIT_HI;
                    end else begin
                        state_r <= SEND;
                    end
                end
                WAIT_HI: begin
                    if (tx_busy) begin
                        state_r <= WAIT_LO;
                    end else begin
                        state_r <= WAIT_HI;
                    end
                end
                WAIT_LO: begin
                    if (!tx_busy) begin
                        if (remain_r != '0) begin
                            state_r <= SEND;
                        end else if (GAP_CYCLES > 0) begin
                            gap_cnt_r <= GAP_LOAD;
                            state_r   <= GAP;
                        end else begin
                            active_r <= 1'b0;
                            state_r  <= IDLE;
                        end
                    end else begin
                        state_r <= WAIT_LO;
                    end
                end
                GAP: begin
                    if (gap_cnt_r == '0) begin
                        active_r <= 1'b0;
                        state_r  <= IDLE;
                    end else begin
                        gap_cnt_r <= gap_cnt_r - GAP_W'(1);
                        state_r   <= GAP;
                    end
                end
                default: begin
                    active_r <= 1'b0;
                    state_r  <= IDLE;
                end
            endcase
        end
    end

    assign req_ready = req_ready_r;
    assign tx_data   = tx_data_r;
    assign tx_start  = tx_start_r;
    assign grant_id  = grant_id_r;
    assign active    = active_r;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Self-checking bench for uart_tx_scheduler: reset values, a table of
// single-packet vectors, hand sequences for round-robin order, zero/overflow
// counts, busy-at-grant and reset mid-packet, then randomized batches
// checked against a queue-based round-robin reference model.
module tb_uart_tx_scheduler;

    localparam int NREQ = 4;
    localparam int GAP  = 6;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  req_valid;
    logic [255:0] req_data;
    logic [15:0] req_count;
    logic [3:0]  req_ready;
    logic [7:0]  tx_data;
    logic        tx_start;
    logic        tx_busy;
    logic [2:0]  grant_id;
    logic        active;

    logic        mbusy;
    logic        force_busy;
    int          busy_left;
    int          busy_len;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    logic prev_active;
    int act_fall_cyc;

    logic [7:0] byte_q[$];
    int         start_q[$];
    int         fall_q[$];
    int         grant_q[$];
    int         gcyc_q[$];

    logic [63:0] rdata[NREQ];
    logic [3:0]  rcnt[NREQ];

    typedef struct {
        int          req;
        logic [3:0]  count;
        logic [63:0] data;
        int          busy;
        int          exp_bytes;
        logic [7:0]  exp_first;
        logic [7:0]  exp_last;
    } vec_t;

    vec_t tbl[6];

    assign tx_busy = mbusy | force_busy;

    always #10 clk = ~clk;

    uart_tx_scheduler #(
        .NUM_REQ    (NREQ),
        .MAX_BYTES  (8),
        .GAP_CYCLES (GAP)
    ) dut (
        .CLOCK_50M (clk),
        .RESET_N   (rst_n),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_count (req_count),
        .req_ready (req_ready),
        .tx_data   (tx_data),
        .tx_start  (tx_start),
        .tx_busy   (tx_busy),
        .grant_id  (grant_id),
        .active    (active)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    // One clock: sample outputs 1 time unit after the edge, then update the
    // requester and transmitter models.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (tx_start) begin
            byte_q.push_back(tx_data);
            start_q.push_back(cyc);
        end
        if ($countones(req_ready) > 1) check("ready_onehot", 64'($countones(req_ready)), 64'd1);
        for (int i = 0; i < NREQ; i++) begin
            if (req_ready[i]) begin
                grant_q.push_back(i);
                gcyc_q.push_back(cyc);
                check("grant_id", 64'(grant_id), 64'(i));
                req_valid[i] = 1'b0;
            end
        end
        if (prev_active && !active) act_fall_cyc = cyc;
        prev_active = active;
        if (tx_start) begin
            mbusy = 1'b1;
            busy_left = busy_len;
        end else if (busy_left > 0) begin
            busy_left--;
            if (busy_left == 0) begin
                mbusy = 1'b0;
                fall_q.push_back(cyc);
            end
        end
    endtask

    task automatic clear_q();
        byte_q.delete();
        start_q.delete();
        fall_q.delete();
        grant_q.delete();
        gcyc_q.delete();
    endtask

    task automatic set_req(input int i, input logic [63:0] d, input logic [3:0] c);
        rdata[i] = d;
        rcnt[i] = c;
        req_data[i*64 +: 64] = d;
        req_count[i*4 +: 4] = c;
        req_valid[i] = 1'b1;
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while ((req_valid != 4'd0 || active || tx_busy) && n < 3000) begin
            tick();
            n++;
        end
        if (n >= 3000) begin
            tests++;
            fails++;
            $display("FAIL %s_timeout: still busy after %0d cycles, required idle", tag, n);
        end
        repeat (2) tick();
    endtask

    function automatic int clampc(input logic [3:0] c);
        return (c > 4'd8) ? 8 : int'(c);
    endfunction

    initial begin
        #1900000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int ptr;
        int fcyc;
        logic [63:0] d;
        int exp_ids[$];
        logic [7:0] exp_bytes[$];

        tbl[0] = '{0, 4'd3,  64'h0000_0000_0043_4241, 10, 3, 8'h41, 8'h43};
        tbl[1] = '{2, 4'd0,  64'h1122_3344_5566_7788, 2,  0, 8'h00, 8'h00};
        tbl[2] = '{1, 4'd12, 64'h8877_6655_4433_2211, 2,  8, 8'h11, 8'h88};
        tbl[3] = '{3, 4'd8,  64'hFEDC_BA98_7654_3210, 3,  8, 8'h10, 8'hFE};
        tbl[4] = '{1, 4'd1,  64'h0000_0000_0000_005A, 1,  1, 8'h5A, 8'h5A};
        tbl[5] = '{3, 4'd9,  64'h0102_0304_0506_0708, 2,  8, 8'h08, 8'h01};

        req_valid = '0; req_data = '0; req_count = '0;
        mbusy = 1'b0; force_busy = 1'b0; busy_left = 0; busy_len = 3;
        prev_active = 1'b0; act_fall_cyc = 0;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        check("rst_req_ready", 64'(req_ready), 64'd0);
        check("rst_tx_start", 64'(tx_start), 64'd0);
        check("rst_tx_data", 64'(tx_data), 64'd0);
        check("rst_grant_id", 64'(grant_id), 64'd0);
        check("rst_active", 64'(active), 64'd0);
        rst_n = 1'b1;
        tick();

        // Round-robin: all four at once, requester 0 re-asserts after 1 is granted
        clear_q();
        for (int i = 0; i < NREQ; i++) set_req(i, 64'(8'hA0 + i), 4'd1);
        n = 0;
        while (n < 3000 && !(grant_q.size() == 5 && !active && req_valid == 4'd0)) begin
            tick();
            n++;
            if (grant_q.size() == 2 && rcnt[0] == 4'd1 && rdata[0] == 64'hA0) set_req(0, 64'hB0, 4'd1);
        end
        check("rr_timeout", 64'(n < 3000), 64'd1);
        wait_done("rr");
        check("rr_grants", 64'(grant_q.size()), 64'd5);
        if (grant_q.size() == 5) begin
            check("rr_g0", 64'(grant_q[0]), 64'd0);
            check("rr_g1", 64'(grant_q[1]), 64'd1);
            check("rr_g2", 64'(grant_q[2]), 64'd2);
            check("rr_g3", 64'(grant_q[3]), 64'd3);
            check("rr_g4", 64'(grant_q[4]), 64'd0);
        end
        check("rr_bytes", 64'(byte_q.size()), 64'd5);
        if (byte_q.size() == 5) begin
            check("rr_b3", 64'(byte_q[3]), 64'hA3);
            check("rr_b4", 64'(byte_q[4]), 64'hB0);
        end

        // Table-driven single packets
        for (int t = 0; t < 6; t++) begin
            clear_q();
            busy_len = tbl[t].busy;
            fcyc = cyc;
            set_req(tbl[t].req, tbl[t].data, tbl[t].count);
            wait_done("tbl");
            check("tbl_ngrant", 64'(grant_q.size()), 64'd1);
            if (grant_q.size() == 1) begin
                check("tbl_grant", 64'(grant_q[0]), 64'(tbl[t].req));
                check("tbl_latency", 64'(gcyc_q[0] - fcyc), 64'd1);
            end
            check("tbl_nbytes", 64'(byte_q.size()), 64'(tbl[t].exp_bytes));
            if (byte_q.size() == tbl[t].exp_bytes && tbl[t].exp_bytes > 0) begin
                check("tbl_first", 64'(byte_q[0]), 64'(tbl[t].exp_first));
                check("tbl_last", 64'(byte_q[byte_q.size()-1]), 64'(tbl[t].exp_last));
                for (int k = 0; k < tbl[t].exp_bytes; k++) begin
                    d = tbl[t].data >> (8 * k);
                    check("tbl_byte", 64'(byte_q[k]), 64'(d[7:0]));
                end
                if (grant_q.size() == 1) check("tbl_first_start", 64'(start_q[0] - gcyc_q[0]), 64'd1);
                for (int k = 1; k < start_q.size(); k++)
                    check("tbl_spacing", 64'(start_q[k] - fall_q[k-1]), 64'd2);
                // WAIT_LO sees the fall one edge later, then GAP cycles elapse
                check("tbl_gap", 64'(act_fall_cyc - fall_q[fall_q.size()-1]), 64'(GAP + 1));
            end
        end

        // Zero count followed immediately by another requester: no gap
        clear_q();
        busy_len = 2;
        set_req(2, 64'h99, 4'd0);
        tick();
        check("zero_grant", 64'(grant_q.size()), 64'd1);
        set_req(3, 64'h77, 4'd1);
        tick();
        check("zero_nogap", 64'(grant_q.size()), 64'd2);
        if (grant_q.size() == 2) check("zero_next", 64'(grant_q[1]), 64'd3);
        wait_done("zero");
        check("zero_bytes", 64'(byte_q.size()), 64'd1);
        if (byte_q.size() == 1) check("zero_byte", 64'(byte_q[0]), 64'h77);

        // Busy held high across the grant
        clear_q();
        force_busy = 1'b1;
        set_req(1, 64'h0000_0000_0000_C3C2, 4'd2);
        repeat (20) tick();
        check("busy_nostart", 64'(byte_q.size()), 64'd0);
        force_busy = 1'b0;
        fcyc = cyc;
        wait_done("busy");
        check("busy_nbytes", 64'(byte_q.size()), 64'd2);
        if (start_q.size() > 0) check("busy_first_start", 64'(start_q[0] - fcyc), 64'd1);
        if (byte_q.size() == 2) check("busy_b1", 64'(byte_q[1]), 64'hC3);

        // Reset during the second of five bytes
        clear_q();
        busy_len = 4;
        set_req(2, 64'h0000_0055_4433_2211, 4'd5);
        n = 0;
        while (byte_q.size() < 2 && n < 300) begin
            tick();
            n++;
        end
        check("rstmid_reach", 64'(byte_q.size()), 64'd2);
        rst_n = 1'b0;
        mbusy = 1'b0;
        busy_left = 0;
        #1;
        check("rstmid_tx_start", 64'(tx_start), 64'd0);
        check("rstmid_tx_data", 64'(tx_data), 64'd0);
        check("rstmid_active", 64'(active), 64'd0);
        check("rstmid_grant_id", 64'(grant_id), 64'd0);
        check("rstmid_ready", 64'(req_ready), 64'd0);
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (30) tick();
        check("rstmid_nomore", 64'(byte_q.size()), 64'd2);
        clear_q();
        set_req(1, 64'hE1, 4'd1);
        set_req(0, 64'hE0, 4'd1);
        wait_done("rstmid");
        check("rstmid_ngrant", 64'(grant_q.size()), 64'd2);
        if (grant_q.size() == 2) begin
            check("rstmid_first", 64'(grant_q[0]), 64'd0);
            check("rstmid_second", 64'(grant_q[1]), 64'd1);
        end
        ptr = 1;

        // Randomized batches vs. round-robin reference model
        for (int b = 0; b < 40; b++) begin
            logic [3:0] mask;
            clear_q();
            exp_ids.delete();
            exp_bytes.delete();
            mask = 4'($urandom_range(1, 15));
            busy_len = $urandom_range(1, 4);
            for (int i = 0; i < NREQ; i++) begin
                rdata[i] = {$urandom, $urandom};
                rcnt[i] = 4'($urandom_range(0, 15));
            end
            for (int k = 1; k <= NREQ; k++) begin
                int id;
                id = (ptr + k) % NREQ;
                if (mask[id]) begin
                    exp_ids.push_back(id);
                    for (int j = 0; j < clampc(rcnt[id]); j++) begin
                        d = rdata[id] >> (8 * j);
                        exp_bytes.push_back(d[7:0]);
                    end
                end
            end
            ptr = exp_ids[exp_ids.size()-1];
            for (int i = 0; i < NREQ; i++) if (mask[i]) set_req(i, rdata[i], rcnt[i]);
            wait_done("rnd");
            check("rnd_ngrant", 64'(grant_q.size()), 64'(exp_ids.size()));
            check("rnd_nbytes", 64'(byte_q.size()), 64'(exp_bytes.size()));
            for (int k = 0; k < grant_q.size() && k < exp_ids.size(); k++)
                check("rnd_grant", 64'(grant_q[k]), 64'(exp_ids[k]));
            for (int k = 0; k < byte_q.size() && k < exp_bytes.size(); k++)
                check("rnd_byte", 64'(byte_q[k]), 64'(exp_bytes[k]));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
